wpn_swing_ctl: RTL and testbench

Sequencer for the melee weapon sprite. It turns a player attack request into a frame-timed swing: windup, swing, recover, then cooldown. It drives the position, flip and enable inputs of the weapon draw stage, and raises a hit window for collision logic. It sits between the player/input logic and the weapon renderer, in the `clk` domain.

---
 rtl/vga_pkg.sv | 7 +
 rtl/wpn_pkg.sv | 41 ++++
 rtl/wpn_pos_calc.sv | 36 +++
 rtl/wpn_swing_ctl.sv | 148 ++++++++++++++
 tb/tb_wpn_swing_ctl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Video timing constants shared by the sprite pipeline.
//   HOR_PIXELS : visible pixels per line
//   VER_PIXELS : visible lines per frame
package vga_pkg;
  localparam int HOR_PIXELS = 640;
  localparam int VER_PIXELS = 480;
endpackage

// File: rtl/wpn_pkg.sv
// Shared types and constants for the melee weapon swing sequencer.
//   wpn_state_t   : sequencer state encoding (also exported on dbg_state)
//   DEF_*_FRAMES  : default frame counts for each timed state
//   clamp_coord() : clamps a signed intermediate into [0, hi]
package wpn_pkg;
  import vga_pkg::*;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WINDUP   = 3'd1,
    ST_SWING    = 3'd2,
    ST_RECOVER  = 3'd3,
    ST_COOLDOWN = 3'd4
  } wpn_state_t;

  localparam int DEF_WINDUP_FRAMES   = 4;
  localparam int DEF_SWING_FRAMES    = 8;
  localparam int DEF_RECOVER_FRAMES  = 4;
  localparam int DEF_COOLDOWN_FRAMES = 20;

  localparam int POS_W  = 12;
  localparam int FCNT_W = 8;
  localparam int LUNGE_W = 8;
  // Two bits of headroom over the 12-bit position so that a full-range
  // char coordinate plus/minus the reach never wraps before clamping.
  localparam int CALC_W = POS_W + 2;

  localparam int X_MAX = HOR_PIXELS - 1;
  localparam int Y_MAX = VER_PIXELS - 1;

  function automatic logic [POS_W-1:0] clamp_coord(
    input logic signed [CALC_W-1:0] v,
    input int                        hi
  );
    logic signed [CALC_W-1:0] hi_s;
    hi_s = signed'(CALC_W'(hi));
    if (v[CALC_W-1])   return '0;
    else if (v > hi_s) return POS_W'(hi);
    else               return v[POS_W-1:0];
  endfunction
endpackage

// File: rtl/wpn_pos_calc.sv
// Combinational weapon position: hand offset plus lunge, mirrored by flip,
// then clamped to the visible screen.
//   char_x/char_y : character centre
//   flip          : 1 = weapon on the left of the character
//   lunge         : extra horizontal reach in px
//   pos_x/pos_y   : clamped weapon centre
module wpn_pos_calc
  import wpn_pkg::*;
#(
  parameter int HAND_OFS_X = 16,
  parameter int HAND_OFS_Y = 8
) (
  input  logic [POS_W-1:0]   char_x,
  input  logic [POS_W-1:0]   char_y,
  input  logic               flip,
  input  logic [LUNGE_W-1:0] lunge,
  output logic [POS_W-1:0]   pos_x,
  output logic [POS_W-1:0]   pos_y
);
  logic signed [CALC_W-1:0] cx_s;
  logic signed [CALC_W-1:0] cy_s;
  logic signed [CALC_W-1:0] reach;
  logic signed [CALC_W-1:0] x_raw;
  logic signed [CALC_W-1:0] y_raw;

  always_comb begin
    cx_s  = signed'({2'b00, char_x});
    cy_s  = signed'({2'b00, char_y});
    reach = signed'(CALC_W'(HAND_OFS_X)) + signed'({{(CALC_W-LUNGE_W){1'b0}}, lunge});
    x_raw = flip ? (cx_s - reach) : (cx_s + reach);
    // Screen y grows downward, so "up" from the centre is a subtraction.
    y_raw = cy_s - signed'(CALC_W'(HAND_OFS_Y));
    pos_x = clamp_coord(x_raw, X_MAX);
    pos_y = clamp_coord(y_raw, Y_MAX);
  end
endmodule

// File: rtl/wpn_swing_ctl.sv
// Melee weapon swing sequencer: IDLE -> WINDUP -> SWING -> RECOVER ->
// COOLDOWN, each timed state lasting a fixed number of frame_ticks.
//   clk, rst_n     : clock, synchronous active-low reset
//   frame_tick     : one-cycle pulse per video frame
//   game_active    : 0 aborts to IDLE and holds there
//   attack_req     : attack button level
//   char_x/y, char_dir : character centre and facing (1 = left)
//   wpn_x/y, wpn_flip, wpn_en : weapon draw-stage controls
//   hit_active     : high during SWING
//   busy           : state is not IDLE
//   swing_done     : one-cycle pulse on RECOVER -> COOLDOWN
//   dbg_state      : current sequencer state
// Handshake: there is none; attack_req is a level sampled only on
// frame_tick while IDLE (or on the COOLDOWN exit tick), otherwise ignored.
// All outputs are registered from next-state values, so a transition on a
// frame_tick edge is visible on the outputs at that same edge.
module wpn_swing_ctl
  import wpn_pkg::*;
#(
  parameter int WINDUP_FRAMES   = DEF_WINDUP_FRAMES,
  parameter int SWING_FRAMES    = DEF_SWING_FRAMES,
  parameter int RECOVER_FRAMES  = DEF_RECOVER_FRAMES,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int HAND_OFS_X      = 16,
  parameter int HAND_OFS_Y      = 8,
  parameter int LUNGE_STEP      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             game_active,
  input  logic             attack_req,
  input  logic [POS_W-1:0] char_x,
  input  logic [POS_W-1:0] char_y,
  input  logic             char_dir,
  output logic [POS_W-1:0] wpn_x,
  output logic [POS_W-1:0] wpn_y,
  output logic             wpn_flip,
  output logic             wpn_en,
  output logic             hit_active,
  output logic             busy,
  output logic             swing_done,
  output wpn_state_t       dbg_state
);
  wpn_state_t          state, state_n;
  logic [FCNT_W-1:0]   fcnt, fcnt_n, fcnt_last;
  logic                flip, flip_n;
  logic [LUNGE_W-1:0]  lunge_n;
  logic [POS_W-1:0]    pos_x, pos_y;

  // Last fcnt value of the current timed state.
  always_comb begin
    fcnt_last = '0;
    case (state)
      ST_WINDUP:   fcnt_last = FCNT_W'(WINDUP_FRAMES - 1);
      ST_SWING:    fcnt_last = FCNT_W'(SWING_FRAMES - 1);
      ST_RECOVER:  fcnt_last = FCNT_W'(RECOVER_FRAMES - 1);
      ST_COOLDOWN: fcnt_last = FCNT_W'(COOLDOWN_FRAMES - 1);
      default:     fcnt_last = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    flip_n  = flip;
    if (!game_active) begin
      // Abort beats any coincident frame_tick.
      state_n = ST_IDLE;
      fcnt_n  = '0;
      flip_n  = 1'b0;
    end else if (state == ST_IDLE) begin
      if (frame_tick && attack_req) begin
        state_n = ST_WINDUP;
        fcnt_n  = '0;
        flip_n  = char_dir;
      end
    end else if (frame_tick) begin
      if (fcnt == fcnt_last) begin
        fcnt_n = '0;
        case (state)
          ST_WINDUP:  state_n = ST_SWING;
          ST_SWING:   state_n = ST_RECOVER;
          ST_RECOVER: state_n = ST_COOLDOWN;
          default: begin
            // COOLDOWN exit: a still-held button restarts straight away,
            // giving a repeat period of exactly the sum of the four states.
            if (attack_req) begin
              state_n = ST_WINDUP;
              flip_n  = char_dir;
            end else begin
              state_n = ST_IDLE;
            end
          end
        endcase
      end else begin
        fcnt_n = fcnt + 1'b1;
      end
    end
  end

  always_comb begin
    lunge_n = '0;
    if (state_n == ST_SWING) lunge_n = LUNGE_W'(LUNGE_STEP) * LUNGE_W'(fcnt_n);
  end

  wpn_pos_calc #(
    .HAND_OFS_X (HAND_OFS_X),
    .HAND_OFS_Y (HAND_OFS_Y)
  ) u_pos (
    .char_x (char_x),
    .char_y (char_y),
    .flip   (flip_n),
    .lunge  (lunge_n),
    .pos_x  (pos_x),
    .pos_y  (pos_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      fcnt       <= '0;
      flip       <= 1'b0;
      wpn_x      <= '0;
      wpn_y      <= '0;
      wpn_flip   <= 1'b0;
      wpn_en     <= 1'b0;
      hit_active <= 1'b0;
      busy       <= 1'b0;
      swing_done <= 1'b0;
    end else begin
      state      <= state_n;
      fcnt       <= fcnt_n;
      flip       <= flip_n;
      // Positions track the character every cycle while a swing is live.
      wpn_x      <= (state_n == ST_IDLE) ? '0 : pos_x;
      wpn_y      <= (state_n == ST_IDLE) ? '0 : pos_y;
      wpn_flip   <= (state_n == ST_IDLE) ? 1'b0 : flip_n;
      wpn_en     <= (state_n == ST_WINDUP) || (state_n == ST_SWING) ||
                    (state_n == ST_RECOVER);
      hit_active <= (state_n == ST_SWING);
      busy       <= (state_n != ST_IDLE);
      swing_done <= (state == ST_RECOVER) && (state_n == ST_COOLDOWN);
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_wpn_swing_ctl.sv
// Bench for wpn_swing_ctl: directed scenarios plus randomized traffic,
// checked every cycle against a timeline model of the swing.
module tb_wpn_swing_ctl;
  import vga_pkg::*;
  import wpn_pkg::*;

  localparam int FRAME_LEN = 4;
  localparam int T_WIND    = 4;
  localparam int T_SWING   = 8;
  localparam int T_REC     = 4;
  localparam int T_COOL    = 20;
  localparam int T_SWING_START = T_WIND;
  localparam int T_REC_START   = T_WIND + T_SWING;
  localparam int T_COOL_START  = T_WIND + T_SWING + T_REC;
  localparam int T_TOTAL       = T_WIND + T_SWING + T_REC + T_COOL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        game_active = 1'b1;
  logic        attack_req = 1'b0;
  logic [11:0] char_x = 12'd320;
  logic [11:0] char_y = 12'd400;
  logic        char_dir = 1'b0;
  logic [11:0] wpn_x, wpn_y;
  logic        wpn_flip, wpn_en, hit_active, busy, swing_done;
  wpn_state_t  dbg_state;

  wpn_swing_ctl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .game_active(game_active),
    .attack_req (attack_req),
    .char_x     (char_x),
    .char_y     (char_y),
    .char_dir   (char_dir),
    .wpn_x      (wpn_x),
    .wpn_y      (wpn_y),
    .wpn_flip   (wpn_flip),
    .wpn_en     (wpn_en),
    .hit_active (hit_active),
    .busy       (busy),
    .swing_done (swing_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];   // frame numbers at which swing_done is due

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A swing is a timeline indexed by frame_ticks since its start tick.
  bit m_active = 0;
  int m_idx    = 0;
  bit m_flip   = 0;
  bit m_done   = 0;
  int frame_no = 0;
  int phase    = 0;
  bit rand_tick = 0;

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_update();
    m_done = 0;
    if (frame_tick) frame_no++;
    if (!rst_n) begin
      m_active = 0; m_idx = 0; m_flip = 0;
    end else if (!game_active) begin
      m_active = 0;
    end else if (m_active) begin
      if (frame_tick) begin
        m_idx++;
        if (m_idx == T_COOL_START) begin
          m_done = 1;
          exp_q.push_back(32'(frame_no));
        end
        if (m_idx == T_TOTAL) begin
          if (attack_req) begin m_idx = 0; m_flip = char_dir; end
          else m_active = 0;
        end
      end
    end else if (frame_tick && attack_req) begin
      m_active = 1; m_idx = 0; m_flip = char_dir;
    end
  endtask

  task automatic compare();
    int lunge, ex, ey;
    bit e_en, e_hit;
    e_en  = m_active && (m_idx < T_COOL_START);
    e_hit = m_active && (m_idx >= T_SWING_START) && (m_idx < T_REC_START);
    lunge = e_hit ? 2 * (m_idx - T_SWING_START) : 0;
    ex = 0; ey = 0;
    if (m_active) begin
      ex = clampi(m_flip ? int'(char_x) - (16 + lunge) : int'(char_x) + (16 + lunge), HOR_PIXELS - 1);
      ey = clampi(int'(char_y) - 8, VER_PIXELS - 1);
    end
    check("wpn_x", 32'(wpn_x), 32'(ex));
    check("wpn_y", 32'(wpn_y), 32'(ey));
    check("wpn_flip", 32'(wpn_flip), 32'(m_active && m_flip));
    check("wpn_en", 32'(wpn_en), 32'(e_en));
    check("hit_active", 32'(hit_active), 32'(e_hit));
    check("busy", 32'(busy), 32'(m_active));
    check("swing_done", 32'(swing_done), 32'(m_done));
    if (!m_active) check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
    if (swing_done) begin
      if (exp_q.size() == 0) check("done_unexpected", 32'(1), 32'(0));
      else check("done_frame", 32'(frame_no), exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set before the edge, the model is advanced with the values
  // sampled at that edge, and outputs are compared 1 time unit later.
  task automatic step();
    if (rand_tick) frame_tick = ($urandom_range(0, 2) == 0);
    else           frame_tick = (phase == FRAME_LEN - 1);
    @(posedge clk);
    model_update();
    #1;
    phase = (phase + 1) % FRAME_LEN;
    compare();
  endtask

  task automatic step_frame();
    do step(); while (!frame_tick);
  endtask

  task automatic run_frames(input int n);
    repeat (n) step_frame();
  endtask

  task automatic start_swing();
    attack_req = 1'b1;
    step_frame();
    attack_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int hit_rise[$];
  bit prev_hit;

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) step();
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_x", 32'(wpn_x), 32'(0));
    rst_n = 1'b1;
    repeat (2) step();

    // Basic swing facing right
    char_x = 12'd320; char_y = 12'd400; char_dir = 1'b0;
    start_swing();
    check("basic_windup_x", 32'(wpn_x), 32'd336);
    check("basic_windup_y", 32'(wpn_y), 32'd392);
    check("basic_windup_en", 32'(wpn_en), 32'd1);
    check("basic_windup_hit", 32'(hit_active), 32'd0);
    run_frames(T_WIND);
    check("basic_swing_first_x", 32'(wpn_x), 32'd336);
    check("basic_swing_hit", 32'(hit_active), 32'd1);
    run_frames(T_SWING - 1);
    check("basic_swing_last_x", 32'(wpn_x), 32'd350);
    run_frames(1);
    check("basic_recover_x", 32'(wpn_x), 32'd336);
    check("basic_recover_hit", 32'(hit_active), 32'd0);
    run_frames(T_REC);
    check("basic_done_pulse", 32'(swing_done), 32'd1);
    check("basic_cool_en", 32'(wpn_en), 32'd0);
    step();
    check("basic_done_single", 32'(swing_done), 32'd0);
    run_frames(T_COOL + 2);
    check("basic_back_idle", 32'(busy), 32'd0);

    // Facing left, direction toggled mid-swing
    char_dir = 1'b1;
    start_swing();
    check("left_windup_x", 32'(wpn_x), 32'd304);
    check("left_flip", 32'(wpn_flip), 32'd1);
    char_dir = 1'b0;
    run_frames(T_WIND + T_SWING - 1);
    check("left_swing_last_x", 32'(wpn_x), 32'd290);
    check("left_flip_held", 32'(wpn_flip), 32'd1);
    run_frames(T_REC + T_COOL + 2);

    // Clamping
    char_x = 12'd5; char_dir = 1'b1;
    start_swing();
    check("clamp_left", 32'(wpn_x), 32'd0);
    char_y = 12'd3;
    step();
    check("clamp_top", 32'(wpn_y), 32'd0);
    run_frames(T_TOTAL + 2);
    char_x = 12'(HOR_PIXELS - 3); char_y = 12'd400; char_dir = 1'b0;
    start_swing();
    check("clamp_right", 32'(wpn_x), 32'(HOR_PIXELS - 1));
    run_frames(T_TOTAL + 2);

    // Held attack: auto-repeat period
    char_x = 12'd320;
    attack_req = 1'b1;
    prev_hit = 1'b0;
    repeat (80 * FRAME_LEN) begin
      step();
      if (hit_active && !prev_hit) hit_rise.push_back(frame_no);
      prev_hit = hit_active;
    end
    attack_req = 1'b0;
    run_frames(T_TOTAL + 2);
    if (hit_rise.size() >= 2) check("held_period", 32'(hit_rise[1] - hit_rise[0]), 32'(T_TOTAL));
    else check("held_two_swings", 32'(hit_rise.size()), 32'd2);

    // Re-press during cooldown is ignored
    start_swing();
    run_frames(T_COOL_START + 2);
    start_swing();
    run_frames(T_COOL);
    check("repress_ignored", 32'(busy), 32'd0);

    // Abort during frame 3 of SWING
    start_swing();
    run_frames(T_WIND + 3);
    step(); step();
    game_active = 1'b0;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_en", 32'(wpn_en), 32'd0);
    check("abort_no_done", 32'(swing_done), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (6) step();
    game_active = 1'b1;
    start_swing();
    check("abort_restart_en", 32'(wpn_en), 32'd1);
    check("abort_restart_hit", 32'(hit_active), 32'd0);
    run_frames(T_TOTAL + 2);

    // Reset mid-RECOVER
    start_swing();
    run_frames(T_REC_START + 1);
    step();
    rst_n = 1'b0;
    step();
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_x", 32'(wpn_x), 32'd0);
    rst_n = 1'b1;
    run_frames(3);
    check("rst_no_start", 32'(busy), 32'd0);
    start_swing();
    check("rst_then_start", 32'(busy), 32'd1);
    run_frames(T_TOTAL + 2);

    // Randomized traffic
    rand_tick = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 19) == 0) attack_req = ~attack_req;
      if ($urandom_range(0, 49) == 0) char_dir = ~char_dir;
      game_active = ($urandom_range(0, 199) != 0);
      rst_n = ($urandom_range(0, 799) != 0);
      case ($urandom_range(0, 9))
        0: char_x = 12'($urandom_range(0, 20));
        1: char_x = 12'($urandom_range(HOR_PIXELS - 20, HOR_PIXELS - 1));
        2: char_y = 12'($urandom_range(0, 12));
        3: char_x = 12'($urandom_range(0, HOR_PIXELS - 1));
        4: char_y = 12'($urandom_range(0, VER_PIXELS - 1));
        5: char_x = 12'($urandom_range(0, 4095));
        default: ;
      endcase
      step();
    end
    rand_tick = 1'b0;
    rst_n = 1'b1; game_active = 1'b1; attack_req = 1'b0;
    run_frames(T_TOTAL + 2);
    check("done_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
